// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory request/grant/response bus plus the
// valid/ready decode output of the fetch unit.
//   master : fetch side (drives imem_req/imem_addr, out_valid/out_pc/out_instr)
//   slave  : memory + decode side (drives imem_gnt/imem_rvalid/imem_rdata, out_ready)
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_gnt, imem_rvalid, imem_rdata, out_ready
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: RV32 instruction-fetch sequencer.
// Issues fetch requests at pc, pairs in-order memory responses with their
// addresses via a 2-entry address queue and hands {pc, instr} to decode
// through a 2-entry valid/ready buffer. Redirects restart fetch and mark
// every in-flight response stale.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   redirect/redirect_pc : one-cycle restart request and target (bits [1:0] forced to 0)
//   pc                   : current fetch pointer
//   bus (master)         : imem request/grant/response + decode output
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MAX_INFLIGHT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  if_fetch_if.master  bus
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fent_t;

  logic        run;          // low for the reset cycle so no request appears during reset
  logic [1:0]  n_out;        // outstanding requests (stale ones included)
  logic [1:0]  n_disc;       // outstanding responses still to be dropped
  logic [1:0]  n_buf;        // decode buffer occupancy
  logic [31:0] aq [2];
  logic        aq_wr, aq_rd;
  fent_t       fb [2];
  logic        fb_wr, fb_rd;

  logic        gnt, rsp, drop, push, pop;
  logic [1:0]  n_out_nx;

  // Credit: in-flight + buffered never exceeds MAX_INFLIGHT, so neither
  // queue can overflow.
  assign bus.imem_req  = run & (({1'b0, n_out} + {1'b0, n_buf}) < 3'(MAX_INFLIGHT));
  assign bus.imem_addr = pc;
  assign bus.out_valid = (n_buf != 2'd0);
  assign bus.out_pc    = fb[fb_rd].pc;
  assign bus.out_instr = fb[fb_rd].instr;

  assign gnt  = bus.imem_req & bus.imem_gnt;
  assign rsp  = bus.imem_rvalid & (n_out != 2'd0);   // stray rvalid ignored
  assign drop = rsp & (n_disc != 2'd0);
  assign push = rsp & ~drop & ~redirect;
  assign pop  = bus.out_valid & bus.out_ready & ~redirect;

  assign n_out_nx = n_out + {1'b0, gnt} - {1'b0, rsp};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      pc     <= RESET_PC;
      n_out  <= 2'd0;
      n_disc <= 2'd0;
      n_buf  <= 2'd0;
      aq[0]  <= '0;
      aq[1]  <= '0;
      aq_wr  <= 1'b0;
      aq_rd  <= 1'b0;
      fb[0]  <= '0;
      fb[1]  <= '0;
      fb_wr  <= 1'b0;
      fb_rd  <= 1'b0;
    end else begin
      run <= 1'b1;

      if (redirect)  pc <= {redirect_pc[31:2], 2'b00};
      else if (gnt)  pc <= pc + 32'd4;

      if (gnt) begin
        aq[aq_wr] <= pc;
        aq_wr     <= ~aq_wr;
      end
      if (rsp) aq_rd <= ~aq_rd;
      n_out <= n_out_nx;

      // Earlier stale responses are already part of n_out, so on a redirect
      // everything still in flight afterwards (incl. a same-cycle grant,
      // which used the old pc) is stale.
      if (redirect)  n_disc <= n_out_nx;
      else if (drop) n_disc <= n_disc - 2'd1;

      if (redirect) begin
        n_buf <= 2'd0;
        fb_wr <= 1'b0;
        fb_rd <= 1'b0;
      end else begin
        if (push) begin
          fb[fb_wr] <= '{pc: aq[aq_rd], instr: bus.imem_rdata};
          fb_wr     <= ~fb_wr;
        end
        if (pop) fb_rd <= ~fb_rd;
        n_buf <= n_buf + {1'b0, push} - {1'b0, pop};
      end
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0), .MAX_INFLIGHT(2)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: fetch pointer, in-flight list (addr, stale, grant cycle)
  // and the decode-side FIFO of {pc, instr}.
  typedef struct { logic [31:0] addr; bit stale; int gcyc; } inf_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ob_t;
  inf_t        infq[$];
  ob_t         obq[$];
  logic [31:0] pc_m;
  bit          started;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs();
    bit exp_req;
    exp_req = started && ((infq.size() + obq.size()) < 2);
    chk("imem_req",  32'(bus.imem_req),  32'(exp_req));
    chk("imem_addr", bus.imem_addr, pc_m);
    chk("pc",        pc,            pc_m);
    chk("out_valid", 32'(bus.out_valid), 32'(obq.size() > 0));
    if (obq.size() > 0) begin
      chk("out_pc",    bus.out_pc,    obq[0].pc);
      chk("out_instr", bus.out_instr, obq[0].instr);
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at negedge.
  task automatic step(input bit g, input bit rv, input bit rdy, input bit rd,
                      input logic [31:0] rpc);
    bit          exp_req, gg, rr;
    logic [31:0] rdat;
    inf_t        e;
    // memory answers no earlier than one cycle after the grant
    if (rv && infq.size() > 0 && infq[0].gcyc >= cyc) rv = 1'b0;
    rdat = $urandom;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdat;
    bus.out_ready   = rdy;
    redirect        = rd;
    redirect_pc     = rpc;
    exp_req = started && ((infq.size() + obq.size()) < 2);
    @(posedge clk);
    gg = exp_req && g;
    rr = rv && (infq.size() > 0);
    if (!rd && rdy && obq.size() > 0) void'(obq.pop_front());
    if (rr) begin
      e = infq.pop_front();
      if (!e.stale && !rd) obq.push_back('{e.addr, rdat});
    end
    if (gg) infq.push_back('{pc_m, rd, cyc});
    if (rd) begin
      foreach (infq[i]) infq[i].stale = 1'b1;
      obq.delete();
      pc_m = {rpc[31:2], 2'b00};
    end else if (gg) begin
      pc_m = pc_m + 32'd4;
    end
    started = 1'b1;
    cyc++;
    @(negedge clk);
    check_outs();
  endtask

  task automatic check_reset_vals();
    chk("rst_imem_req",  32'(bus.imem_req),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc",    bus.out_pc,    32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_pc",        pc,            32'd0);
  endtask

  // Called at a negedge: asynchronous reset mid-cycle, stray rvalid while held.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    infq.delete();
    obq.delete();
    pc_m    = 32'd0;
    started = 1'b0;
    bus.imem_rvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    pc_m = 32'd0; started = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;

    step(0, 0, 1, 0, 32'h0);                            // first request after release
    repeat (8) step(1, 1, 1, 0, 32'h0);                 // streaming
    repeat (5) step(1, 1, 0, 0, 32'h0);                 // back-pressure
    repeat (6) step(1, 1, 1, 0, 32'h0);                 // drain and resume
    repeat (3) step(0, 1, 1, 0, 32'h0);                 // grant stall
    step(1, 0, 0, 0, 32'h0);
    step(1, 0, 0, 1, 32'h0000_0203);                    // redirect with work in flight
    repeat (6) step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 1, 32'hFFFF_FFFC);                    // redirect to top of memory
    repeat (4) step(1, 1, 1, 0, 32'h0);                 // wraps to 0
    step(1, 0, 1, 1, 32'h0000_0100);                    // back-to-back redirects
    step(1, 0, 1, 1, 32'h0000_0300);
    repeat (6) step(1, 1, 1, 0, 32'h0);
    do_reset();                                         // mid-stream reset
    step(0, 1, 1, 0, 32'h0);                            // stray rvalid ignored

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
